pipeline_debug_controller: RTL and testbench
============================================

# pipeline_debug_controller

Run controller for the MIPS_DLX pipeline. It takes single-byte commands from the UART receive FIFO and drives the pipeline `enable` in continuous or single-step mode. It counts executed cycles. After every step or halt it serializes a snapshot of the 322-bit pipeline debug bus, plus the cycle count, into the UART transmit FIFO. It sits between the UART and MIPS_DLX at top level.

## Interface
- `DBG_W`, 322: width of the pipeline debug bus.
- `CNT_W`, 32: cycle counter width; must be a multiple of 8.
- `HALT_WORD`, 32'hFFFF_FFFF: IF/ID instruction value that stops continuous run.
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `debug_signal`  in  DBG_W  pipeline debug bus. Bits [321:290] are the IF/ID instruction latch.
- `rx_empty`  in  1  UART RX FIFO empty. `r_data` is valid whenever this is low (first-word fall-through).
- `r_data`  in  8  RX FIFO head byte.
- `rd`  out  1  one-cycle pop of the RX FIFO.
- `tx_full`  in  1  UART TX FIFO full.
- `w_data`  out  8  byte to transmit.
- `wr`  out  1  one-cycle push to the TX FIFO.
- `pipe_enable`  out  1  drives MIPS_DLX `enable`.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, RUN, STEP, LOAD, SEND.
- Commands are ASCII, 1 byte each:
  - `c` (8'h63): continuous run.
  - `s` (8'h73): single step.
  - `d` (8'h64): dump without stepping.
  - `p` (8'h70): pause; valid only in RUN.
  - Any other byte is popped and ignored.
- IDLE:
  - If `!rx_empty`, assert `rd` and decode `r_data` in the same cycle.
  - `c` -> RUN.
  - `s` -> STEP.
  - `d` -> LOAD.
  - Otherwise stay in IDLE.
- RUN:
  - `pipe_enable` = 1 and `cycle_cnt` += 1 each cycle, unless exiting.
  - Halt exit: `debug_signal[321:290] == HALT_WORD`. In that cycle `pipe_enable` = 0, no count, next state LOAD.
  - Pause exit: `!rx_empty && r_data == p`. Assert `rd`, `pipe_enable` = 0, no count, next state LOAD. If halt and `p` coincide, the byte is still popped.
  - Any non-`p` byte in RUN is popped and ignored; the run continues.
- STEP:
  - `pipe_enable` = 1 for exactly one cycle, `cycle_cnt` += 1, then LOAD.
  - A step is taken even if the halt word is present.
- LOAD (one cycle):
  - Capture `{cycle_cnt, 6'b0, debug_signal}` into the snapshot register (CNT_W+328 bits).
  - Set the byte index to 0, then go to SEND.
- SEND:
  - When `!tx_full`: assert `wr`, `w_data` = the snapshot byte at the current index (MSB first), increment the index.
  - When `tx_full`: `wr` = 0 and `w_data` holds its value.
  - After the last byte (index = CNT_W/8 + 41 - 1 = 44 at defaults) go to IDLE. Frame length is 45 bytes.
  - `rd` = 0 in STEP, LOAD and SEND; commands wait in the FIFO.
- Counter: `cycle_cnt` wraps modulo 2^CNT_W. It is cleared only by reset.

## Timing
- Reset values: state IDLE, `cycle_cnt` 0, snapshot 0, index 0; `rd` 0, `wr` 0, `w_data` 8'h00, `pipe_enable` 0, `busy` 0.
- Reset during RUN or SEND aborts at once. No further `wr`; `pipe_enable` drops on the next edge.
- `rd`, `wr` and `pipe_enable` are combinational from state and inputs.
- The snapshot register, counter and index are registered.
- Command `s` popped at cycle T:
  - `pipe_enable` high in cycle T+1.
  - LOAD at T+2.
  - First `wr` at T+3 if the TX FIFO is not full.
- Snapshot reflects pipeline state after the last enabled edge.
- Step/halt -> dump needs no further command. Minimum time from LOAD to IDLE is 45 cycles with no backpressure.

## Structure
- Shared package `debug_pkg`:
  - State enum.
  - Command byte constants `CMD_RUN`, `CMD_STEP`, `CMD_DUMP`, `CMD_PAUSE`.
  - Frame length constant.
- One sub-module, `snapshot_serializer`:
  - Snapshot register and byte index.
  - `load`, `tx_full` -> `wr`, `w_data`, `done`.
- FSM, counter and command decode stay in the top module.

## Test plan
- Reset, then `d` with `debug_signal` = all-ones:
  - 45 bytes sent: 4 x 8'h00 (count), then 8'h03, then 40 x 8'hFF.
  - Returns to IDLE; `pipe_enable` never asserted.
- `s` three times:
  - `pipe_enable` high for exactly 3 single cycles.
  - Count bytes in the three frames are 1, 2, 3.
- `c`, then halt word in IF/ID after 10 enabled cycles:
  - `pipe_enable` low in the halt cycle.
  - Frame count = 10.
- `c`, then `p` queued after 5 cycles:
  - `rd` pulses.
  - Frame count = 5.
  - Unknown byte 8'h41 during RUN popped without stopping.
- `tx_full` toggled every other cycle during SEND:
  - Bytes arrive in order with no loss or duplication.
  - Exactly 45 `wr` pulses.
- Reset asserted mid-SEND at byte 20:
  - `wr` stops from the next cycle.
  - All outputs at reset values; a subsequent `d` sends a complete frame with count 0.

Source files
------------

// File: rtl/debug_pkg.sv
// Shared types and constants for the pipeline debug/run controller.
package debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_STEP,
    ST_LOAD,
    ST_SEND
  } state_t;

  localparam logic [7:0] CMD_RUN   = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_DUMP  = 8'h64;  // 'd'
  localparam logic [7:0] CMD_PAUSE = 8'h70;  // 'p'

  // Debug bus is zero-padded up to a whole number of bytes in the snapshot.
  localparam int SNAP_PAD_W = 328;

  function automatic int frame_len(input int cnt_w);
    return cnt_w / 8 + SNAP_PAD_W / 8;
  endfunction

  localparam int FRAME_LEN = frame_len(32);

endpackage

// File: rtl/snapshot_serializer.sv
// Captures {cycle count, padded debug bus} and streams it MSB byte first.
module snapshot_serializer
  import debug_pkg::*;
#(
  parameter int DBG_W = 322,
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             send,
  input  logic             tx_full,
  input  logic [CNT_W-1:0] cycle_cnt,
  input  logic [DBG_W-1:0] debug_signal,
  output logic             wr,
  output logic [7:0]       w_data,
  output logic             done
);

  localparam int SNAP_W = CNT_W + SNAP_PAD_W;
  localparam int NBYTES = frame_len(CNT_W);
  localparam int IDX_W  = $clog2(NBYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic [SNAP_W-1:0] snap_q;
  logic [IDX_W-1:0]  idx_q;
  logic [7:0]        last_q;

  // The snapshot shifts left on each push, so the head byte is always the
  // next one to go out; last_q keeps w_data stable while the FIFO is full.
  assign wr     = send && !tx_full;
  assign done   = wr && (idx_q == LAST_IDX);
  assign w_data = wr ? snap_q[SNAP_W-1 -: 8] : last_q;

  // Snapshot capture, byte shift-out and index tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      snap_q <= '0;
      idx_q  <= '0;
      last_q <= '0;
    end else if (load) begin
      snap_q <= {cycle_cnt, SNAP_PAD_W'(debug_signal)};
      idx_q  <= '0;
    end else if (wr) begin
      snap_q <= snap_q << 8;
      last_q <= snap_q[SNAP_W-1 -: 8];
      idx_q  <= idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_debug_controller.sv
// UART-driven run/step controller for MIPS_DLX with snapshot dump.
module pipeline_debug_controller
  import debug_pkg::*;
#(
  parameter int          DBG_W     = 322,
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DBG_W-1:0] debug_signal,
  input  logic             rx_empty,
  input  logic [7:0]       r_data,
  output logic             rd,
  input  logic             tx_full,
  output logic [7:0]       w_data,
  output logic             wr,
  output logic             pipe_enable,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt;
  logic             halt, pause, load, send, done;

  // Top 32 bits of the debug bus are the IF/ID instruction latch.
  assign halt  = (debug_signal[DBG_W-1 -: 32] == HALT_WORD);
  assign pause = !rx_empty && (r_data == CMD_PAUSE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_empty) begin
          case (r_data)
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: state_d = ST_LOAD;
            default:  state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN:  if (halt || pause) state_d = ST_LOAD;
      ST_STEP: state_d = ST_LOAD;
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: if (done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: commands are only consumed in IDLE and RUN; any byte in RUN is
  // popped, including a 'p' that coincides with the halt word.
  always_comb begin
    rd          = 1'b0;
    pipe_enable = 1'b0;
    load        = 1'b0;
    send        = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: rd = !rx_empty;
      ST_RUN: begin
        rd          = !rx_empty;
        pipe_enable = !halt && !pause;
      end
      ST_STEP: pipe_enable = 1'b1;
      ST_LOAD: load = 1'b1;
      ST_SEND: send = 1'b1;
      default: ;
    endcase
  end

  // Executed-cycle counter; wraps naturally and only reset clears it.
  always_ff @(posedge clock) begin
    if (reset)            cycle_cnt <= '0;
    else if (pipe_enable) cycle_cnt <= cycle_cnt + 1'b1;
  end

  snapshot_serializer #(
    .DBG_W(DBG_W),
    .CNT_W(CNT_W)
  ) u_ser (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .send        (send),
    .tx_full     (tx_full),
    .cycle_cnt   (cycle_cnt),
    .debug_signal(debug_signal),
    .wr          (wr),
    .w_data      (w_data),
    .done        (done)
  );

endmodule

// File: tb/tb_pipeline_debug_controller.sv
// Directed bench for pipeline_debug_controller with RX/TX FIFO models.
module tb_pipeline_debug_controller;

  localparam int DBG_W = 322;
  localparam int CNT_W = 32;
  localparam int NB    = 45;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [DBG_W-1:0] debug_signal = '0;
  logic             rx_empty = 1'b1;
  logic [7:0]       r_data = 8'h00;
  logic             rd;
  logic             tx_full = 1'b0;
  logic [7:0]       w_data;
  logic             wr;
  logic             pipe_enable;
  logic             busy;

  pipeline_debug_controller #(
    .DBG_W(DBG_W), .CNT_W(CNT_W), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clock(clock), .reset(reset), .debug_signal(debug_signal),
    .rx_empty(rx_empty), .r_data(r_data), .rd(rd),
    .tx_full(tx_full), .w_data(w_data), .wr(wr),
    .pipe_enable(pipe_enable), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [7:0] rxq[$];
  logic [7:0] txlog[$];
  int   n_chk = 0, n_pass = 0;
  int   en_cycles = 0, en_consec = 0, stall_seen = 0, stall_bad = 0;
  logic prev_en = 1'b0, tx_toggle = 1'b0;
  logic s_rd, s_wr, s_en, s_busy;
  logic [7:0] s_wdata;

  // One clock: present RX head, sample outputs mid-cycle, model FIFOs.
  task automatic tick();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
    #1;
    s_rd = rd; s_wr = wr; s_en = pipe_enable; s_busy = busy; s_wdata = w_data;
    if (busy && tx_full && !wr && txlog.size() > 0) begin
      stall_seen++;
      if (w_data !== txlog[txlog.size()-1]) stall_bad++;
    end
    if (rd && rxq.size() > 0) void'(rxq.pop_front());
    if (wr) txlog.push_back(w_data);
    if (pipe_enable) begin
      en_cycles++;
      if (prev_en) en_consec++;
    end
    prev_en = pipe_enable;
    @(posedge clock);
    #1;
    if (tx_toggle) tx_full = ~tx_full;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    rxq.delete(); txlog.delete();
    en_cycles = 0; en_consec = 0; prev_en = 1'b0;
    tx_full = 1'b0; tx_toggle = 1'b0;
    stall_seen = 0; stall_bad = 0;
  endtask

  // Bounded wait until a frame has gone out and the controller is idle.
  task automatic wait_frame(input string tag);
    int budget = 400;
    while (budget > 0 && !(txlog.size() >= NB && !busy)) begin
      tick();
      budget--;
    end
    n_chk++;
    if (budget == 0)
      $display("FAIL %s_timeout: sent %0d bytes busy=%b, required %0d bytes then idle",
               tag, txlog.size(), busy, NB);
    else n_pass++;
  endtask

  function automatic logic [7:0] exp_byte(input logic [31:0] cnt,
                                          input logic [DBG_W-1:0] dbg, input int i);
    logic [CNT_W+327:0] snap;
    snap = {cnt, 6'b0, dbg};
    return snap[CNT_W+327-8*i -: 8];
  endfunction

  function automatic logic [31:0] frame_cnt();
    if (txlog.size() < 4) return 32'hDEAD_BEEF;
    return {txlog[0], txlog[1], txlog[2], txlog[3]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_chk++; if (s_rd !== 1'b0) $display("FAIL reset_rd: got %b want 0", s_rd); else n_pass++;
    n_chk++; if (s_wr !== 1'b0) $display("FAIL reset_wr: got %b want 0", s_wr); else n_pass++;
    n_chk++; if (s_wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", s_wdata); else n_pass++;
    n_chk++; if (s_en !== 1'b0) $display("FAIL reset_en: got %b want 0", s_en); else n_pass++;
    n_chk++; if (s_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", s_busy); else n_pass++;
    do_reset();
  endtask

  task automatic test_dump();
    logic [7:0] want;
    debug_signal = '1;
    rxq.push_back(8'h64);
    tick();
    n_chk++; if (s_rd !== 1'b1) $display("FAIL dump_rd: got %b want 1", s_rd); else n_pass++;
    wait_frame("dump");
    n_chk++; if (txlog.size() != NB) $display("FAIL dump_len: got %0d want %0d", txlog.size(), NB); else n_pass++;
    for (int i = 0; i < NB && i < txlog.size(); i++) begin
      want = (i < 4) ? 8'h00 : (i == 4) ? 8'h03 : 8'hFF;
      n_chk++;
      if (txlog[i] !== want) $display("FAIL dump_byte%0d: got %h want %h", i, txlog[i], want);
      else n_pass++;
    end
    n_chk++; if (en_cycles != 0) $display("FAIL dump_noenable: got %0d enabled cycles want 0", en_cycles); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL dump_idle: busy=%b want 0", busy); else n_pass++;
    debug_signal = '0;
  endtask

  task automatic test_step();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      txlog.delete();
      rxq.push_back(8'h73);
      tick();
      n_chk++; if (s_rd !== 1'b1 || s_en !== 1'b0) $display("FAIL step%0d_pop: rd=%b en=%b want rd=1 en=0", k, s_rd, s_en); else n_pass++;
      tick();
      n_chk++; if (s_en !== 1'b1) $display("FAIL step%0d_enable: got %b want 1", k, s_en); else n_pass++;
      tick();
      n_chk++; if (s_en !== 1'b0 || s_wr !== 1'b0) $display("FAIL step%0d_load: en=%b wr=%b want 0 0", k, s_en, s_wr); else n_pass++;
      tick();
      n_chk++; if (s_wr !== 1'b1 || s_wdata !== 8'h00) $display("FAIL step%0d_firstwr: wr=%b data=%h want 1 00", k, s_wr, s_wdata); else n_pass++;
      wait_frame("step");
      n_chk++; if (frame_cnt() !== 32'(k)) $display("FAIL step%0d_count: got %0d want %0d", k, frame_cnt(), k); else n_pass++;
    end
    n_chk++; if (en_cycles != 3) $display("FAIL step_total: got %0d enabled cycles want 3", en_cycles); else n_pass++;
    n_chk++; if (en_consec != 0) $display("FAIL step_single: got %0d back-to-back enables want 0", en_consec); else n_pass++;
  endtask

  task automatic test_halt();
    int budget = 50;
    do_reset();
    rxq.push_back(8'h63);
    tick();
    while (en_cycles < 10 && budget > 0) begin tick(); budget--; end
    n_chk++; if (en_cycles != 10) $display("FAIL halt_run: got %0d enabled cycles want 10", en_cycles); else n_pass++;
    debug_signal[321:290] = 32'hFFFF_FFFF;
    tick();
    n_chk++; if (s_en !== 1'b0 || s_busy !== 1'b1) $display("FAIL halt_cycle: en=%b busy=%b want 0 1", s_en, s_busy); else n_pass++;
    wait_frame("halt");
    n_chk++; if (frame_cnt() !== 32'd10) $display("FAIL halt_count: got %0d want 10", frame_cnt()); else n_pass++;
    n_chk++; if (txlog.size() > 5 && txlog[4] !== 8'h03) $display("FAIL halt_ifid: got %h want 03", txlog[4]); else n_pass++;
    debug_signal = '0;
  endtask

  task automatic test_pause();
    do_reset();
    rxq.push_back(8'h63);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rxq.push_back(8'h41);
      tick();
      n_chk++; if (s_en !== 1'b1) $display("FAIL pause_run%0d: en=%b want 1", i, s_en); else n_pass++;
      if (i == 2) begin
        n_chk++; if (s_rd !== 1'b1) $display("FAIL pause_unknown_pop: rd=%b want 1", s_rd); else n_pass++;
      end
    end
    rxq.push_back(8'h70);
    tick();
    n_chk++; if (s_rd !== 1'b1 || s_en !== 1'b0) $display("FAIL pause_cycle: rd=%b en=%b want 1 0", s_rd, s_en); else n_pass++;
    wait_frame("pause");
    n_chk++; if (frame_cnt() !== 32'd5) $display("FAIL pause_count: got %0d want 5", frame_cnt()); else n_pass++;
    n_chk++; if (rxq.size() != 0) $display("FAIL pause_rxq: %0d bytes left want 0", rxq.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [DBG_W-1:0] dbg;
    int bad = 0;
    do_reset();
    for (int k = 0; k < DBG_W; k++) dbg[k] = ((k * 5) % 7) < 3;
    debug_signal = dbg;
    rxq.push_back(8'h64);
    tick();
    tx_toggle = 1'b1;
    wait_frame("bp");
    tx_toggle = 1'b0; tx_full = 1'b0;
    n_chk++; if (txlog.size() != NB) $display("FAIL bp_len: got %0d wr pulses want %0d", txlog.size(), NB); else n_pass++;
    for (int i = 0; i < NB && i < txlog.size(); i++) begin
      n_chk++;
      if (txlog[i] !== exp_byte(32'd0, dbg, i)) begin
        $display("FAIL bp_byte%0d: got %h want %h", i, txlog[i], exp_byte(32'd0, dbg, i));
        bad++;
      end else n_pass++;
    end
    n_chk++; if (stall_seen == 0 || stall_bad != 0) $display("FAIL bp_hold: stalls=%0d held_wrong=%0d want >0 and 0", stall_seen, stall_bad); else n_pass++;
    debug_signal = '0;
  endtask

  task automatic test_reset_mid_send();
    int budget = 100;
    do_reset();
    debug_signal = {DBG_W/2{2'b10}};
    rxq.push_back(8'h64);
    tick();
    while (txlog.size() < 20 && budget > 0) begin tick(); budget--; end
    n_chk++; if (txlog.size() != 20) $display("FAIL rst_reach20: got %0d bytes want 20", txlog.size()); else n_pass++;
    reset = 1'b1;
    tick();
    tick();
    n_chk++; if (s_wr !== 1'b0) $display("FAIL rst_wr: got %b want 0", s_wr); else n_pass++;
    n_chk++; if (s_rd !== 1'b0 || s_en !== 1'b0) $display("FAIL rst_rd_en: rd=%b en=%b want 0 0", s_rd, s_en); else n_pass++;
    n_chk++; if (s_wdata !== 8'h00 || s_busy !== 1'b0) $display("FAIL rst_outs: wdata=%h busy=%b want 00 0", s_wdata, s_busy); else n_pass++;
    reset = 1'b0;
    txlog.delete();
    debug_signal = '1;
    rxq.push_back(8'h64);
    tick();
    wait_frame("rst");
    n_chk++; if (txlog.size() != NB) $display("FAIL rst_len: got %0d want %0d", txlog.size(), NB); else n_pass++;
    n_chk++; if (frame_cnt() !== 32'd0) $display("FAIL rst_count: got %0d want 0", frame_cnt()); else n_pass++;
    n_chk++; if (txlog.size() == NB && (txlog[4] !== 8'h03 || txlog[44] !== 8'hFF)) $display("FAIL rst_bytes: b4=%h b44=%h want 03 FF", txlog[4], txlog[44]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_dump();
    test_step();
    test_halt();
    test_pause();
    test_backpressure();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
